alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised ALU execution unit for the multicycle RISC-V core: decodes ALUOp/funct3/funct7 into a full RV32I ALU operation set plus the M extension, and executes it under a start/done handshake with the control FSM. Simple ops complete in one cycle. MUL*/DIV*/REM* run an iterative shift-add or restoring-division datapath over XLEN cycles. It replaces the combinational 2-bit ALU control decode and sits between the control FSM and the A/B operand registers.

## Interface
- XLEN, 32, datapath width (power of two, ≥8)
- MUL_EN, 1, 1 = M-extension ops implemented; 0 = M ops flagged illegal
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request, sampled only in IDLE
- alu_op  in  2  00 = ADD (fetch/address), 01 = SUB (branch compare), 10 = R-type, 11 = I-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B / immediate
- result  out  XLEN  registered result, held until next done
- zero  out  1  registered (result == 0)
- busy  out  1  unit occupied
- done  out  1  one-cycle completion pulse
- illegal  out  1  registered, valid with done: undefined encoding

## Operation
- Decode at start (operands and controls latched; inputs may change afterwards):
  - alu_op 10, funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by funct3.
  - alu_op 10, funct7 0100000: funct3 000 = SUB, 101 = SRA; any other funct3 is illegal.
  - alu_op 10, funct7 0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3. Illegal if MUL_EN=0.
  - alu_op 11: funct7 is ignored except funct3 101, where funct7[5] selects SRA. funct3 000 is always ADD.
  - Any other alu_op 10 funct7 is illegal.
- Shift amount is src_b[log2(XLEN)-1:0]. SLT/SLTU return 0 or 1, zero-extended.
- Signed M ops: take operand magnitudes, run the unsigned core, then negate the result when the signs differ.
  - MULHSU treats only A as signed.
  - REM takes the sign of the dividend.
- Short-circuit cases complete in one cycle:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give src_a.
  - Signed overflow (most-negative ÷ −1): DIV gives most-negative; REM gives 0.
- Illegal encodings complete in one cycle with result 0 and illegal=1.
- States:
  - IDLE: on start, go to CALC for iterative ops, otherwise to DONE.
  - CALC: XLEN iterations, counter 0..XLEN-1, then go to FIX.
  - FIX: sign-correct, write result, go to DONE.
  - DONE: done=1, return to IDLE.
- Each CALC iteration performs one shift-add step on a 2·XLEN product, or one restoring subtract on the remainder/quotient.

## Timing
- Reset (asynchronous, any state): state IDLE; result, zero, busy, done, illegal, and counter all 0. Any in-flight operation is discarded.
- Edge 0 is the edge sampling start=1 in IDLE.
- Single-cycle ops, short-circuit cases and illegal encodings:
  - result, zero and illegal register at edge 0.
  - busy and done are high for exactly the cycle after edge 0.
- Iterative ops:
  - busy rises after edge 0.
  - CALC occupies edges 1..XLEN.
  - FIX registers result at edge XLEN+1.
  - done is high for the one cycle following edge XLEN+1.
  - busy stays high through that cycle and falls after edge XLEN+2.
- start while busy=1 is ignored; no queueing.
- start asserted during the done cycle is ignored; it is accepted next cycle in IDLE.
- result is stable from done until the next completion.

## Test plan
- Reset:
  - rst_n low mid-CALC (DIV in flight) → busy, done, result, illegal drop to 0 immediately, without a clock edge.
  - Next start ADD 3+4 → result 7 one cycle later.
- ALU basics (XLEN=32):
  - alu_op 10, f3 000, f7 0100000, A=5, B=7 → result 0xFFFFFFFE, zero 0, done one cycle after start.
  - alu_op 01, A=B=9 → result 0, zero 1.
- I-type shift:
  - alu_op 11, f3 101, f7 0100000, A=0x80000000, B=4 → 0xF8000000.
  - Same with f7 0000000 → 0x08000000.
- Multiply:
  - MUL A=0x12345678, B=0x10 → 0x23456780.
  - MULH A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
  - Both: done after edge 33 (result registered there); start pulses during busy are ignored.
- Divide:
  - DIV A=−7, B=2 → 0xFFFFFFFD.
  - REM A=−7, B=2 → 0xFFFFFFFF.
  - DIVU A=7, B=0 → 0xFFFFFFFF in one cycle.
  - REM A=0x80000000, B=0xFFFFFFFF → 0 in one cycle.
- Illegal encodings:
  - alu_op 10, f7 0000010 → illegal 1, result 0, done one cycle later.
  - MUL_EN=0 with MUL → illegal 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/M ALU execution unit with a start/done handshake.
// Simple ops, divide-by-zero, signed-overflow and illegal encodings finish in
// one cycle. MUL*/DIV*/REM* run XLEN shift-add / restoring-divide iterations
// on unsigned operand magnitudes, then get sign-corrected in FIX.
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  LAST_CNT = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  op_t               dec_op, op_q;
  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] acc, acc_init, acc_step, fixed_prod;
  logic [XLEN-1:0]   opnd, opnd_init;
  logic              neg_q, neg_init, is_mul_q, is_mul_op;
  logic [XLEN-1:0]   simple_res, fast_res, fix_res, mag_a, mag_b;
  logic [XLEN-1:0]   quo_fix, rem_fix, div_diff;
  logic              fast, a_neg, b_neg, b_zero, sovf, div_ge;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [SHW-1:0]    shamt;

  // Map alu_op/funct3/funct7 to a concrete operation; anything unlisted is illegal.
  always_comb begin
    dec_op = OP_ILL;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec_op = OP_SUB;
          else if (funct3 == 3'b101) dec_op = OP_SRA;
        end else if (funct7 == 7'b0000001 && MUL_EN) begin
          case (funct3)
            3'b000:  dec_op = OP_MUL;
            3'b001:  dec_op = OP_MULH;
            3'b010:  dec_op = OP_MULHSU;
            3'b011:  dec_op = OP_MULHU;
            3'b100:  dec_op = OP_DIV;
            3'b101:  dec_op = OP_DIVU;
            3'b110:  dec_op = OP_REM;
            default: dec_op = OP_REMU;
          endcase
        end
      end
      default: begin
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = funct7[5] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    endcase
  end

  // Single-cycle result, short-circuit detection and operand magnitudes for the iterative core.
  always_comb begin
    shamt      = src_b[SHW-1:0];
    simple_res = '0;
    case (dec_op)
      OP_ADD:  simple_res = src_a + src_b;
      OP_SUB:  simple_res = src_a - src_b;
      OP_SLL:  simple_res = src_a << shamt;
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_XOR:  simple_res = src_a ^ src_b;
      OP_SRL:  simple_res = src_a >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(src_a) >>> shamt);
      OP_OR:   simple_res = src_a | src_b;
      OP_AND:  simple_res = src_a & src_b;
      default: simple_res = '0;
    endcase

    b_zero = (src_b == '0);
    sovf   = (src_a == MOST_NEG) && (src_b == '1);
    fast   = 1'b1;
    fast_res = simple_res;
    case (dec_op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: fast = 1'b0;
      OP_DIV: begin
        if (b_zero)    fast_res = '1;
        else if (sovf) fast_res = MOST_NEG;
        else           fast = 1'b0;
      end
      OP_DIVU: begin
        if (b_zero) fast_res = '1;
        else        fast = 1'b0;
      end
      OP_REM: begin
        if (b_zero)    fast_res = src_a;
        else if (sovf) fast_res = '0;
        else           fast = 1'b0;
      end
      OP_REMU: begin
        if (b_zero) fast_res = src_a;
        else        fast = 1'b0;
      end
      default: ;
    endcase

    a_neg = src_a[XLEN-1] && (dec_op == OP_MULH || dec_op == OP_MULHSU ||
                              dec_op == OP_DIV  || dec_op == OP_REM);
    b_neg = src_b[XLEN-1] && (dec_op == OP_MULH || dec_op == OP_DIV || dec_op == OP_REM);
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;
    is_mul_op = (dec_op == OP_MUL || dec_op == OP_MULH ||
                 dec_op == OP_MULHSU || dec_op == OP_MULHU);
    neg_init  = (dec_op == OP_REM || dec_op == OP_REMU) ? a_neg : (a_neg ^ b_neg);
    // Multiply: low half holds the multiplier; divide: low half holds the dividend.
    acc_init  = is_mul_op ? {{XLEN{1'b0}}, mag_b} : {{XLEN{1'b0}}, mag_a};
    opnd_init = is_mul_op ? mag_a : mag_b;
  end

  // One iteration: shift-add on the product, or restoring subtract on remainder/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (is_mul_q) acc_step = {mul_sum, acc[XLEN-1:1]};
    else          acc_step = {div_ge ? div_diff : div_shift[XLEN-1:0], acc[XLEN-2:0], div_ge};
  end

  // Sign correction and result selection after the last iteration.
  always_comb begin
    fixed_prod = neg_q ? -acc : acc;
    quo_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix    = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                         fix_res = fixed_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = fixed_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fix_res = quo_fix;
      OP_REM, OP_REMU:                fix_res = rem_fix;
      default:                        fix_res = '0;
    endcase
  end

  // Control FSM with registered outputs; operands latch at start so inputs may move afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      is_mul_q <= 1'b0;
      op_q     <= OP_ADD;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (fast) begin
              result  <= fast_res;
              zero    <= (fast_res == '0);
              illegal <= (dec_op == OP_ILL);
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              acc      <= acc_init;
              opnd     <= opnd_init;
              neg_q    <= neg_init;
              is_mul_q <= is_mul_op;
              op_q     <= dec_op;
              cnt      <= '0;
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= S_FIX;
        end
        S_FIX: begin
          result  <= fix_res;
          zero    <= (fix_res == '0);
          illegal <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
